johnson_phase_tracker: RTL and testbench

Decodes a registered N-bit Johnson code stream into a binary phase index and a one-hot phase vector. It checks every sample for code legality and correct successor order. A HUNT/LOCKED state machine reports whether the stream is a clean, in-sequence Johnson count. It sits directly downstream of the Johnson counter and feeds phase-driven logic and the status/debug path.

---
 rtl/johnson_phase_tracker_pkg.sv | 16 +
 rtl/johnson_decode.sv | 35 +++
 rtl/johnson_phase_tracker.sv | 161 ++++++++++++++++
 tb/tb_johnson_phase_tracker.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/johnson_phase_tracker_pkg.sv
// Shared types and constants for the Johnson phase tracker.
// Holds the HUNT/LOCKED state enum, the error-count width and the phase-width helper.
package johnson_phase_tracker_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } track_state_e;

    localparam int ERR_CNT_W = 16;

    function automatic int phase_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality flag and binary phase index.
// A code is legal when it has at most one transition between adjacent bits.
module johnson_decode
    import johnson_phase_tracker_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = phase_w(N)
) (
    input  logic [N-1:0]  code_i,
    output logic          legal_o,
    output logic [PW-1:0] phase_o
);

    int ones;
    int trans;

    always_comb begin
        ones  = 0;
        trans = 0;
        for (int i = 0; i < N; i++) begin
            ones = ones + int'(code_i[i]);
        end
        for (int i = 1; i < N; i++) begin
            trans = trans + int'(code_i[i] ^ code_i[i-1]);
        end
        legal_o = (trans <= 1);
        // Ones anchored at the MSB count up; ones anchored at the LSB count down from 2N.
        if (code_i[N-1] || (ones == 0)) begin
            phase_o = PW'(ones);
        end else begin
            phase_o = PW'(2 * N - ones);
        end
    end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Johnson code stream tracker: registered phase decode, order checking and HUNT/LOCKED status.
// Define JOHNSON_TRACK_ERRCNT_EN to build the saturating error counter; otherwise err_count_o is 0.
module johnson_phase_tracker
    import johnson_phase_tracker_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2,
    localparam int PW = phase_w(N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 code_valid_i,
    input  logic [N-1:0]         code_i,
    output logic [PW-1:0]        phase_o,
    output logic [2*N-1:0]       phase_onehot_o,
    output logic                 phase_valid_o,
    output logic                 locked_o,
    output logic                 illegal_o,
    output logic                 step_err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);

    track_state_e   state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [2*N-1:0] onehot_q, onehot_d;
    logic           phase_valid_q, phase_valid_d;
    logic           have_prev_q, have_prev_d;
    logic           illegal_q, illegal_d;
    logic           step_err_q, step_err_d;
    logic [RW-1:0]  run_q, run_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic           err_inc;

    logic           dec_legal;
    logic [PW-1:0]  dec_phase;
    logic [PW-1:0]  succ_phase;

    johnson_decode #(.N(N)) u_decode (
        .code_i  (code_i),
        .legal_o (dec_legal),
        .phase_o (dec_phase)
    );

    // phase_q always holds the last legal phase, so it doubles as prev_phase.
    assign succ_phase = (phase_q == PW'(2 * N - 1)) ? '0 : phase_q + PW'(1);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        have_prev_d   = have_prev_q;
        run_d         = run_q;
        miss_d        = miss_q;
        illegal_d     = 1'b0;
        step_err_d    = 1'b0;
        err_inc       = 1'b0;
        onehot_d      = '0;

        if (code_valid_i) begin
            if (!dec_legal) begin
                illegal_d     = 1'b1;
                err_inc       = 1'b1;
                run_d         = '0;
                have_prev_d   = 1'b0;
                phase_valid_d = 1'b0;
            end else begin
                phase_d       = dec_phase;
                phase_valid_d = 1'b1;
                have_prev_d   = 1'b1;
                if (have_prev_q && (dec_phase == succ_phase)) begin
                    run_d = (run_q == RW'(LOCK_CNT)) ? run_q : run_q + RW'(1);
                end else if (have_prev_q) begin
                    step_err_d = 1'b1;
                    err_inc    = 1'b1;
                    run_d      = RW'(1);
                end else begin
                    run_d = RW'(1);
                end
            end

            case (state_q)
                HUNT: begin
                    miss_d = '0;
                    if (run_d == RW'(LOCK_CNT)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!err_inc) begin
                        miss_d = '0;
                    end else if (miss_q == MW'(LOSS_CNT - 1)) begin
                        state_d = HUNT;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MW'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    miss_d  = '0;
                end
            endcase
        end

        if (phase_valid_d) begin
            onehot_d[phase_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= HUNT;
            phase_q       <= '0;
            onehot_q      <= '0;
            phase_valid_q <= 1'b0;
            have_prev_q   <= 1'b0;
            illegal_q     <= 1'b0;
            step_err_q    <= 1'b0;
            run_q         <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            onehot_q      <= onehot_d;
            phase_valid_q <= phase_valid_d;
            have_prev_q   <= have_prev_d;
            illegal_q     <= illegal_d;
            step_err_q    <= step_err_d;
            run_q         <= run_d;
            miss_q        <= miss_d;
        end
    end

`ifdef JOHNSON_TRACK_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= '0;
        end else if (err_inc && (err_q != '1)) begin
            err_q <= err_q + ERR_CNT_W'(1);
        end
    end

    assign err_count_o = err_q;
`else
    assign err_count_o = '0;
`endif

    assign phase_o        = phase_q;
    assign phase_onehot_o = onehot_q;
    assign phase_valid_o  = phase_valid_q;
    assign locked_o       = (state_q == LOCKED);
    assign illegal_o      = illegal_q;
    assign step_err_o     = step_err_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed bench for johnson_phase_tracker with N=4, LOCK_CNT=4, LOSS_CNT=2.
// Expected error counts follow JOHNSON_TRACK_ERRCNT_EN.
module tb_johnson_phase_tracker;

`ifdef JOHNSON_TRACK_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        code_valid;
    logic [3:0]  code;
    logic [2:0]  phase;
    logic [7:0]  phase_onehot;
    logic        phase_valid;
    logic        locked;
    logic        illegal;
    logic        step_err;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

    johnson_phase_tracker #(.N(4), .LOCK_CNT(4), .LOSS_CNT(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .code_valid_i   (code_valid),
        .code_i         (code),
        .phase_o        (phase),
        .phase_onehot_o (phase_onehot),
        .phase_valid_o  (phase_valid),
        .locked_o       (locked),
        .illegal_o      (illegal),
        .step_err_o     (step_err),
        .err_count_o    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err(input int n);
        return ERRCNT_ON ? n : 0;
    endfunction

    task automatic check_outs(input string tag, input int ph, input int pv, input int lk,
                              input int il, input int se, input int ec);
        int oh;
        oh = pv ? (1 << ph) : 0;
        check({tag, ".phase"}, int'(phase), ph);
        check({tag, ".onehot"}, int'(phase_onehot), oh);
        check({tag, ".phase_valid"}, int'(phase_valid), pv);
        check({tag, ".locked"}, int'(locked), lk);
        check({tag, ".illegal"}, int'(illegal), il);
        check({tag, ".step_err"}, int'(step_err), se);
        check({tag, ".err_count"}, int'(err_count), ec);
        check({tag, ".exclusive"}, int'(illegal & step_err), 0);
    endtask

    task automatic sample(input logic v, input logic [3:0] c);
        @(negedge clk);
        code_valid = v;
        code       = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        code_valid = 1'b1;
        code       = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        rstn       = 1'b1;
        code_valid = 1'b0;

        // Clean lock from 0000 upward.
        sample(1'b1, 4'b0000); check_outs("lock0", 0, 1, 0, 0, 0, exp_err(0));
        sample(1'b1, 4'b1000); check_outs("lock1", 1, 1, 0, 0, 0, exp_err(0));
        sample(1'b1, 4'b1100); check_outs("lock2", 2, 1, 0, 0, 0, exp_err(0));
        sample(1'b1, 4'b1110); check_outs("lock3", 3, 1, 1, 0, 0, exp_err(0));
        sample(1'b1, 4'b1111); check_outs("ph4", 4, 1, 1, 0, 0, exp_err(0));
        sample(1'b1, 4'b0111); check_outs("ph5", 5, 1, 1, 0, 0, exp_err(0));

        // Wrap through 7->0 with idle cycles in between; idle codes are ignored.
        sample(1'b1, 4'b0011); check_outs("wrap6", 6, 1, 1, 0, 0, exp_err(0));
        sample(1'b1, 4'b0001); check_outs("wrap7", 7, 1, 1, 0, 0, exp_err(0));
        sample(1'b0, 4'b0101); check_outs("idle1", 7, 1, 1, 0, 0, exp_err(0));
        sample(1'b0, 4'b1111); check_outs("idle2", 7, 1, 1, 0, 0, exp_err(0));
        sample(1'b1, 4'b0000); check_outs("wrap0", 0, 1, 1, 0, 0, exp_err(0));

        // Illegal code while locked.
        sample(1'b1, 4'b0101); check_outs("illegal", 0, 0, 1, 1, 0, exp_err(1));
        sample(1'b0, 4'b0000); check_outs("ill_idle", 0, 0, 1, 0, 0, exp_err(1));
        sample(1'b1, 4'b1000); check_outs("recov1", 1, 1, 1, 0, 0, exp_err(1));
        sample(1'b1, 4'b1100); check_outs("recov2", 2, 1, 1, 0, 0, exp_err(1));

        // Loss of lock after two consecutive step errors.
        sample(1'b1, 4'b1111); check_outs("loss1", 4, 1, 1, 0, 1, exp_err(2));
        sample(1'b1, 4'b0011); check_outs("loss2", 6, 1, 0, 0, 1, exp_err(3));
        sample(1'b1, 4'b0011); check_outs("repeat", 6, 1, 0, 0, 1, exp_err(4));
        sample(1'b0, 4'b0011); check_outs("hunt_idle", 6, 1, 0, 0, 0, exp_err(4));

        // Mid-stream reset discards history.
        @(negedge clk);
        rstn       = 1'b0;
        code_valid = 1'b1;
        code       = 4'b0001;
        @(posedge clk);
        #1;
        check_outs("midreset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn       = 1'b1;
        code_valid = 1'b0;
        sample(1'b1, 4'b1110); check_outs("post_rst3", 3, 1, 0, 0, 0, exp_err(0));
        sample(1'b1, 4'b1111); check_outs("post_rst4", 4, 1, 0, 0, 0, exp_err(0));

        // Error-count saturation with a long run of illegal samples.
        @(negedge clk);
        code_valid = 1'b1;
        code       = 4'b0101;
        repeat (70000) @(posedge clk);
        #1;
        code_valid = 1'b0;
        check_outs("saturate", 4, 0, 0, 1, 0, exp_err(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
